// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman word loader and player guess path.
// Key class vectors are one-hot, indexed by the KC_* constants below.
package hangman_pkg;

  typedef enum logic [1:0] {
    ENTRY  = 2'd0,
    ARM    = 2'd1,
    LOCKED = 2'd2
  } loader_state_t;

  localparam logic [7:0] KEY_BKSP    = 8'h08;
  localparam logic [7:0] KEY_ENTER   = 8'h0D;
  localparam logic [7:0] KEY_CLEAR   = 8'h1B;
  localparam logic [7:0] UPPER_LO    = 8'h41;
  localparam logic [7:0] UPPER_HI    = 8'h5A;
  localparam logic [7:0] LOWER_LO    = 8'h61;
  localparam logic [7:0] LOWER_HI    = 8'h7A;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  localparam int unsigned WORD_LEN_DEF = 5;

  localparam int unsigned KC_LETTER = 0;
  localparam int unsigned KC_BKSP   = 1;
  localparam int unsigned KC_ENTER  = 2;
  localparam int unsigned KC_CLEAR  = 3;
  localparam int unsigned KC_OTHER  = 4;
  localparam int unsigned KC_NUM    = 5;

endpackage

// File: rtl/key_classifier.sv
// Combinational key decoder: one-hot key class plus upper-case folded letter.
// The class vector is all-zero when no key is valid.
module key_classifier
  import hangman_pkg::*;
(
  input  logic [7:0]        i_key_data,
  input  logic              i_key_valid,
  output logic [KC_NUM-1:0] o_key_class,
  output logic [7:0]        o_letter
);

  logic w_upper;
  logic w_lower;

  always_comb begin
    w_upper     = (i_key_data >= UPPER_LO) && (i_key_data <= UPPER_HI);
    w_lower     = (i_key_data >= LOWER_LO) && (i_key_data <= LOWER_HI);
    o_letter    = w_lower ? (i_key_data - CASE_OFFSET) : i_key_data;
    o_key_class = '0;
    if (i_key_valid) begin
      if (w_upper || w_lower)          o_key_class[KC_LETTER] = 1'b1;
      else if (i_key_data == KEY_BKSP)  o_key_class[KC_BKSP]   = 1'b1;
      else if (i_key_data == KEY_ENTER) o_key_class[KC_ENTER]  = 1'b1;
      else if (i_key_data == KEY_CLEAR) o_key_class[KC_CLEAR]  = 1'b1;
      else                              o_key_class[KC_OTHER]  = 1'b1;
    end
  end

endmodule

// File: rtl/host_word_loader.sv
// Host-side secret word entry: edits, confirms and hands the word to the game controller,
// holding it frozen while a round runs.
module host_word_loader
  import hangman_pkg::*;
#(
  parameter int unsigned WORD_LEN = WORD_LEN_DEF,
  parameter int unsigned CNT_W    = 3
) (
  input  logic                  clk,
  input  logic                  nRst,
  input  logic [7:0]            key_data,
  input  logic                  key_valid,
  input  logic                  game_rdy,
  input  logic                  game_over,
  output logic [8*WORD_LEN-1:0] setWord,
  output logic                  toggle_state,
  output logic [CNT_W-1:0]      word_len,
  output logic                  word_full,
  output logic                  locked,
  output logic                  key_reject
);

  localparam int unsigned        WordW  = 8 * WORD_LEN;
  localparam logic [CNT_W-1:0]   LenMax = CNT_W'(WORD_LEN);

  logic [KC_NUM-1:0] w_class;
  logic [7:0]        w_letter;
  logic              w_any_key;
  logic              w_cancel;

  loader_state_t     r_state, w_state_d;
  logic [WordW-1:0]  r_word, w_word_d, w_edit_word;
  logic [CNT_W-1:0]  r_len, w_len_d, w_edit_len;
  logic              r_full, r_locked, r_toggle, r_reject;
  logic              w_toggle_d, w_reject_d, w_edit_reject, w_edit_arm;

  key_classifier u_key_classifier (
    .i_key_data  (key_data),
    .i_key_valid (key_valid),
    .o_key_class (w_class),
    .o_letter    (w_letter)
  );

  assign w_any_key = |w_class;
  assign w_cancel  = w_class[KC_BKSP] | w_class[KC_CLEAR];

  // Effect of a key under entry rules; reused when a cancel key drops ARM back to ENTRY.
  always_comb begin
    w_edit_word   = r_word;
    w_edit_len    = r_len;
    w_edit_reject = 1'b0;
    w_edit_arm    = 1'b0;
    unique case (1'b1)
      w_class[KC_LETTER]: begin
        if (r_len < LenMax) begin
          for (int unsigned i = 0; i < WORD_LEN; i++) begin
            if (r_len == CNT_W'(i)) w_edit_word[8*(WORD_LEN-1-i) +: 8] = w_letter;
          end
          w_edit_len = r_len + CNT_W'(1);
        end else begin
          w_edit_reject = 1'b1;
        end
      end
      w_class[KC_BKSP]: begin
        if (r_len != '0) begin
          for (int unsigned i = 0; i < WORD_LEN; i++) begin
            if (r_len == CNT_W'(i + 1)) w_edit_word[8*(WORD_LEN-1-i) +: 8] = 8'h00;
          end
          w_edit_len = r_len - CNT_W'(1);
        end else begin
          w_edit_reject = 1'b1;
        end
      end
      w_class[KC_CLEAR]: begin
        w_edit_word = '0;
        w_edit_len  = '0;
      end
      w_class[KC_ENTER]: begin
        if (r_len == LenMax) w_edit_arm    = 1'b1;
        else                 w_edit_reject = 1'b1;
      end
      w_class[KC_OTHER]: w_edit_reject = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_state_d  = r_state;
    w_word_d   = r_word;
    w_len_d    = r_len;
    w_toggle_d = 1'b0;
    w_reject_d = 1'b0;
    unique case (r_state)
      ENTRY: begin
        w_word_d   = w_edit_word;
        w_len_d    = w_edit_len;
        w_reject_d = w_edit_reject;
        if (w_edit_arm) w_state_d = ARM;
      end
      ARM: begin
        if (w_cancel) begin
          w_state_d  = ENTRY;
          w_word_d   = w_edit_word;
          w_len_d    = w_edit_len;
          w_reject_d = w_edit_reject;
        end else begin
          w_reject_d = w_any_key;
          if (game_rdy) begin
            w_toggle_d = 1'b1;
            w_state_d  = LOCKED;
          end
        end
      end
      LOCKED: begin
        w_reject_d = w_any_key;
        if (game_over) begin
          w_state_d = ENTRY;
          w_word_d  = '0;
          w_len_d   = '0;
        end
      end
      default: begin
        w_state_d = ENTRY;
        w_word_d  = '0;
        w_len_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state  <= ENTRY;
      r_word   <= '0;
      r_len    <= '0;
      r_full   <= 1'b0;
      r_locked <= 1'b0;
      r_toggle <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_word   <= w_word_d;
      r_len    <= w_len_d;
      r_full   <= (w_len_d == LenMax);
      r_locked <= (w_state_d == LOCKED);
      r_toggle <= w_toggle_d;
      r_reject <= w_reject_d;
    end
  end

  assign setWord      = r_word;
  assign word_len     = r_len;
  assign word_full    = r_full;
  assign locked       = r_locked;
  assign toggle_state = r_toggle;
  assign key_reject   = r_reject;

endmodule

// File: tb/tb_host_word_loader.sv
// Directed bench for host_word_loader: queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_host_word_loader;

  localparam int unsigned WL = 5;

  logic            clk = 1'b0;
  logic            nRst;
  logic [7:0]      key_data = 8'h00;
  logic            key_valid = 1'b0;
  logic            game_rdy = 1'b0;
  logic            game_over = 1'b0;
  logic [8*WL-1:0] setWord;
  logic            toggle_state;
  logic [2:0]      word_len;
  logic            word_full;
  logic            locked;
  logic            key_reject;

  int n_tests = 0;
  int n_fail  = 0;

  host_word_loader dut (
    .clk          (clk),
    .nRst         (nRst),
    .key_data     (key_data),
    .key_valid    (key_valid),
    .game_rdy     (game_rdy),
    .game_over    (game_over),
    .setWord      (setWord),
    .toggle_state (toggle_state),
    .word_len     (word_len),
    .word_full    (word_full),
    .locked       (locked),
    .key_reject   (key_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word as a queue of letters, round phase 0=entry 1=armed 2=locked.
  logic [7:0] m_word[$];
  int         m_phase  = 0;
  logic       m_toggle = 1'b0;
  logic       m_reject = 1'b0;

  function automatic int kind(input logic [7:0] b);
    if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) return 0;
    if (b == 8'h08) return 1;
    if (b == 8'h0D) return 2;
    if (b == 8'h1B) return 3;
    return 4;
  endfunction

  function automatic logic [8*WL-1:0] packed_word();
    logic [8*WL-1:0] v = '0;
    for (int i = 0; i < WL; i++) v = (v << 8) | ((i < m_word.size()) ? m_word[i] : 8'h00);
    return v;
  endfunction

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      m_word.delete();
      m_phase  = 0;
      m_toggle = 1'b0;
      m_reject = 1'b0;
    end else begin
      int k;
      k = kind(key_data);
      m_toggle = 1'b0;
      m_reject = 1'b0;
      if (m_phase == 1 && key_valid && (k == 1 || k == 3)) m_phase = 0;
      else if (m_phase == 1) begin
        m_reject = key_valid;
        if (game_rdy) begin
          m_toggle = 1'b1;
          m_phase  = 2;
        end
        k = -1;
      end
      if (m_phase == 0 && key_valid && k >= 0) begin
        case (k)
          0: if (m_word.size() < WL)
               m_word.push_back((key_data >= 8'h61) ? key_data - 8'h20 : key_data);
             else m_reject = 1'b1;
          1: if (m_word.size() > 0) void'(m_word.pop_back()); else m_reject = 1'b1;
          2: if (m_word.size() == WL) m_phase = 1; else m_reject = 1'b1;
          3: m_word.delete();
          default: m_reject = 1'b1;
        endcase
      end else if (m_phase == 2 && k >= 0) begin
        m_reject = key_valid;
        if (game_over) begin
          m_phase = 0;
          m_word.delete();
        end
      end
    end
  end

  logic prev_toggle = 1'b0;
  always @(negedge clk) begin
    chk("m_setWord", setWord, packed_word());
    chk("m_word_len", word_len, m_word.size());
    chk("m_word_full", word_full, m_word.size() == WL);
    chk("m_locked", locked, m_phase == 2);
    chk("m_toggle", toggle_state, m_toggle);
    chk("m_reject", key_reject, m_reject);
    if (prev_toggle) chk("toggle_double", toggle_state, 1'b0);
    prev_toggle = toggle_state;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [7:0] b);
    key_data  = b;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_key(s[i]);
  endtask

  initial begin
    nRst = 1'b0;
    repeat (2) tick();
    chk("rst_setWord", setWord, 0);
    chk("rst_len", word_len, 0);
    chk("rst_flags", {toggle_state, word_full, locked, key_reject}, 4'b0000);
    nRst = 1'b1;
    tick();

    // Lower/mixed case folded into HELLO
    send_key(8'h68); send_key(8'h65); send_key(8'h4C); send_key(8'h4C); send_key(8'h6F);
    chk("hello_word", setWord, 40'h48454C4C4F);
    chk("hello_len", word_len, 5);
    chk("hello_full", word_full, 1);
    chk("hello_norej", key_reject, 0);
    send_key(8'h1B);
    chk("clear_len", word_len, 0);

    send_str("AB"); send_key(8'h08); send_str("C");
    chk("bksp_word", setWord, 40'h4143000000);
    chk("bksp_len", word_len, 2);
    send_str("DEF");
    send_key("G");
    chk("sixth_rej", key_reject, 1);
    chk("sixth_word", setWord, 40'h4143444546);
    tick();
    chk("rej_pulse", key_reject, 0);
    send_key(8'h1B);

    // Confirm, controller busy for 10 cycles
    send_str("HELLO");
    send_key(8'h0D);
    chk("arm_norej", key_reject, 0);
    repeat (10) begin
      chk("arm_notog", toggle_state, 0);
      tick();
    end
    game_rdy = 1'b1;
    tick();
    chk("toggle_hi", toggle_state, 1);
    chk("locked_hi", locked, 1);
    tick();
    game_rdy = 1'b0;
    chk("toggle_lo", toggle_state, 0);
    chk("locked_stay", locked, 1);

    send_key("Z");
    chk("lock_rej", key_reject, 1);
    chk("lock_word", setWord, 40'h48454C4C4F);
    key_data = "Q"; key_valid = 1'b1; game_over = 1'b1;
    tick();
    key_valid = 1'b0; game_over = 1'b0;
    chk("over_word", setWord, 0);
    chk("over_locked", locked, 0);
    chk("over_rej", key_reject, 1);
    send_key("Q");
    chk("entry_again", setWord, 40'h5100000000);
    send_key(8'h1B);

    send_str("abc");
    send_key(8'h0D);
    chk("short_enter_rej", key_reject, 1);
    send_key("d");
    chk("still_entry", word_len, 4);
    send_key(8'h31);
    chk("digit_rej", key_reject, 1);
    send_key(8'h1B);
    chk("clear_len0", word_len, 0);
    chk("clear_norej", key_reject, 0);
    send_key(8'h1B);
    chk("clear_empty_norej", key_reject, 0);
    send_key(8'h08);
    chk("bksp_empty_rej", key_reject, 1);

    // Cancel beats game_rdy in the same cycle
    send_str("HELLO");
    send_key(8'h0D);
    game_rdy = 1'b1;
    send_key(8'h08);
    game_rdy = 1'b0;
    chk("cancel_notog", toggle_state, 0);
    chk("cancel_word", setWord, 40'h48454C4C00);
    chk("cancel_len", word_len, 4);
    game_rdy = 1'b1;
    repeat (2) tick();
    chk("cancel_nolock", locked, 0);
    game_rdy = 1'b0;

    // Reset while armed
    send_str("O");
    send_key(8'h0D);
    tick();
    #2 nRst = 1'b0;
    #1;
    chk("arst_word", setWord, 0);
    chk("arst_len", word_len, 0);
    chk("arst_flags", {toggle_state, word_full, locked, key_reject}, 4'b0000);
    tick();
    nRst = 1'b1;
    game_rdy = 1'b1;
    repeat (3) begin
      tick();
      chk("post_rst_notog", toggle_state, 0);
    end
    game_rdy = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
